// File: rtl/voice_mixer.sv
// Stereo voice mixer: walks NVOICE voices once per sample-rate load, pans each voice into
// left/right accumulators, applies master volume and saturates to 24-bit outputs.
module voice_mixer #(
  parameter int unsigned NVOICE = 8,
  parameter int unsigned VW     = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  output logic [2:0]           voice_sel,
  input  logic signed [VW-1:0] voice_data,
  input  logic [7:0]           pan,
  input  logic [7:0]           vol,
  input  logic                 clip_clr,
  output logic signed [23:0]   l_data,
  output logic signed [23:0]   r_data,
  output logic                 busy,
  output logic                 clip,
  output logic                 overrun
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  // tick counts edges since the load edge; the whole pass is scheduled from it
  localparam logic [3:0] LastFetch = 4'(NVOICE - 1);
  localparam logic [3:0] LastDrain = 4'(NVOICE + 3);
  localparam logic [3:0] AccFirst  = 4'd2;
  localparam logic [3:0] AccLast   = 4'(NVOICE + 1);
  localparam logic [3:0] OutTick   = 4'(NVOICE + 4);

  localparam logic signed [36:0] SatMax = 37'sd8388607;
  localparam logic signed [36:0] SatMin = -37'sd8388608;

  state_e state_q, state_d;
  logic [3:0] tick_q;
  logic [7:0] vol_q;
  logic start, finish, acc_en;

  logic signed [25:0] vd_ext, lw, rw, lp_d, rp_d, lp_q, rp_q;
  logic signed [28:0] acc_l_q, acc_r_q;
  logic signed [36:0] vol_ext, prod_l_d, prod_r_d, prod_l_q, prod_r_q, shl, shr;
  logic signed [23:0] sat_l_d, sat_r_d, sat_l_q, sat_r_q;
  logic               ovf_l_d, ovf_r_d, ovf_l_q, ovf_r_q;

  assign start  = load && (state_q == StIdle) && !busy;
  assign finish = busy && (tick_q == OutTick);
  assign acc_en = busy && (tick_q >= AccFirst) && (tick_q <= AccLast);

  assign voice_sel = (state_q == StFetch) ? tick_q[2:0] : 3'd0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (tick_q == LastFetch) state_d = StDrain;
      StDrain: if (tick_q == LastDrain) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: signed sample times unsigned pan weights
  always_comb begin
    vd_ext = 26'(voice_data);
    lw     = $signed({18'd0, 8'd255 - pan});
    rw     = $signed({18'd0, pan});
    lp_d   = vd_ext * lw;
    rp_d   = vd_ext * rw;
  end

  // Stage 3: volume, floor shift, saturate
  always_comb begin
    vol_ext  = $signed({29'd0, vol_q});
    prod_l_d = 37'(acc_l_q) * vol_ext;
    prod_r_d = 37'(acc_r_q) * vol_ext;
    shl      = prod_l_q >>> 12;
    shr      = prod_r_q >>> 12;
    ovf_l_d  = 1'b1;
    ovf_r_d  = 1'b1;
    if (shl > SatMax)      sat_l_d = 24'sh7fffff;
    else if (shl < SatMin) sat_l_d = -24'sh800000;
    else begin
      sat_l_d = shl[23:0];
      ovf_l_d = 1'b0;
    end
    if (shr > SatMax)      sat_r_d = 24'sh7fffff;
    else if (shr < SatMin) sat_r_d = -24'sh800000;
    else begin
      sat_r_d = shr[23:0];
      ovf_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      vol_q    <= '0;
      busy     <= 1'b0;
      clip     <= 1'b0;
      overrun  <= 1'b0;
      lp_q     <= '0;
      rp_q     <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      prod_l_q <= '0;
      prod_r_q <= '0;
      sat_l_q  <= '0;
      sat_r_q  <= '0;
      ovf_l_q  <= 1'b0;
      ovf_r_q  <= 1'b0;
      l_data   <= '0;
      r_data   <= '0;
    end else begin
      state_q  <= state_d;
      lp_q     <= lp_d;
      rp_q     <= rp_d;
      prod_l_q <= prod_l_d;
      prod_r_q <= prod_r_d;
      sat_l_q  <= sat_l_d;
      sat_r_q  <= sat_r_d;
      ovf_l_q  <= ovf_l_d;
      ovf_r_q  <= ovf_r_d;

      if (load && busy) overrun <= 1'b1;

      if (start) begin
        tick_q  <= '0;
        vol_q   <= vol;
        busy    <= 1'b1;
        acc_l_q <= '0;
        acc_r_q <= '0;
      end else begin
        if (busy) tick_q <= tick_q + 4'd1;
        if (acc_en) begin
          acc_l_q <= acc_l_q + 29'(lp_q);
          acc_r_q <= acc_r_q + 29'(rp_q);
        end
        if (finish) begin
          busy   <= 1'b0;
          l_data <= sat_l_q;
          r_data <= sat_r_q;
        end
      end

      // a saturation landing with clip_clr still sets the flag
      if (finish && (ovf_l_q || ovf_r_q)) clip <= 1'b1;
      else if (clip_clr)                  clip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed cases plus randomized passes against an
// arithmetic model of the pan/volume/saturation rules.
module tb_voice_mixer;

  localparam int N  = 8;
  localparam int VW = 18;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 load = 1'b0;
  logic [2:0]           voice_sel;
  logic signed [VW-1:0] voice_data = '0;
  logic [7:0]           pan = '0;
  logic [7:0]           vol = '0;
  logic                 clip_clr = 1'b0;
  logic signed [23:0]   l_data, r_data;
  logic                 busy, clip, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int bank_v [N];
  int bank_p [N];

  longint exp_l, exp_r;
  logic   exp_sat;
  logic   clip_exp;
  int     lat;

  voice_mixer #(.NVOICE(N), .VW(VW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .voice_sel  (voice_sel),
    .voice_data (voice_data),
    .pan        (pan),
    .vol        (vol),
    .clip_clr   (clip_clr),
    .l_data     (l_data),
    .r_data     (r_data),
    .busy       (busy),
    .clip       (clip),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // registered voice-bank read
  always @(posedge clk) begin
    voice_data <= VW'(bank_v[voice_sel]);
    pan        <= 8'(bank_p[voice_sel]);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint scale_sat(input longint acc, input int v, output logic s);
    longint x;
    x = (acc * v) >>> 12;
    s = 1'b0;
    if (x > 8388607) begin
      x = 8388607;
      s = 1'b1;
    end else if (x < -8388608) begin
      x = -8388608;
      s = 1'b1;
    end
    return x;
  endfunction

  task automatic model(input int v);
    longint al, ar;
    logic   sl, sr;
    al = 0;
    ar = 0;
    for (int i = 0; i < N; i++) begin
      al += longint'(bank_v[i]) * (255 - bank_p[i]);
      ar += longint'(bank_v[i]) * bank_p[i];
    end
    exp_l   = scale_sat(al, v, sl);
    exp_r   = scale_sat(ar, v, sr);
    exp_sat = sl | sr;
  endtask

  task automatic fill(input int v, input int p);
    for (int i = 0; i < N; i++) begin
      bank_v[i] = v;
      bank_p[i] = p;
    end
  endtask

  // Pulse load, optionally a second load sec_at edges later; lat = edges until busy drops.
  task automatic do_pass(input int sec_at, output int lat_o);
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat_o = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      load = 1'b0;
      if (!busy) begin
        lat_o = i;
        break;
      end
      if (i + 1 == sec_at) load = 1'b1;
    end
  endtask

  initial begin
    fill(0, 0);
    clip_exp = 1'b0;

    // reset held with load pulsing
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load = ~load;
    end
    @(negedge clk);
    load = 1'b0;
    chk("rst_l", l_data, 0);
    chk("rst_r", r_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_sel", voice_sel, 0);
    reset = 1'b1;
    @(negedge clk);

    // single voice, hard left
    fill(0, 0);
    bank_v[0] = 65536;
    vol = 8'd255;
    do_pass(0, lat);
    chk("single_lat", lat, N + 5);
    chk("single_l", l_data, 1040400);
    chk("single_r", r_data, 0);

    // centre pan
    fill(-131072, 128);
    do_pass(0, lat);
    chk("centre_l", l_data, -8290560);
    chk("centre_r", r_data, -8355840);
    chk("centre_clip", clip, 0);

    // saturation then clear
    fill(131071, 0);
    do_pass(0, lat);
    chk("sat_l", l_data, 8388607);
    chk("sat_r", r_data, 0);
    chk("sat_clip", clip, 1);
    @(negedge clk);
    chk("hold_l", l_data, 8388607);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    chk("clr_clip", clip, 0);

    // overrun: second load 3 edges after the first
    fill(0, 0);
    bank_v[0] = 65536;
    do_pass(3, lat);
    chk("ovr_lat", lat, N + 5);
    chk("ovr_flag", overrun, 1);
    chk("ovr_l", l_data, 1040400);
    chk("ovr_r", r_data, 0);

    // reset in FETCH cycle 4
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_l", l_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ovr", overrun, 0);
    chk("mid_sel", voice_sel, 0);
    reset = 1'b1;
    repeat (N + 8) @(negedge clk);
    chk("mid_nopartial", l_data, 0);
    fill(-131072, 128);
    do_pass(0, lat);
    chk("mid_next_l", l_data, -8290560);
    chk("mid_next_r", r_data, -8355840);

    // randomized passes
    clip_exp = 1'b0;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        bank_v[i] = int'($urandom_range(0, 262143)) - 131072;
        if (t % 4 == 1) bank_v[i] = bank_v[i] / 16;
        case ($urandom_range(0, 4))
          0:       bank_p[i] = 0;
          1:       bank_p[i] = 255;
          default: bank_p[i] = int'($urandom_range(0, 255));
        endcase
      end
      vol = (t % 6 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        clip_exp = 1'b0;
      end
      model(int'(vol));
      do_pass(0, lat);
      clip_exp = clip_exp | exp_sat;
      chk($sformatf("rnd%0d_lat", t), lat, N + 5);
      chk($sformatf("rnd%0d_l", t), l_data, exp_l);
      chk($sformatf("rnd%0d_r", t), r_data, exp_r);
      chk($sformatf("rnd%0d_clip", t), clip, clip_exp);
      chk($sformatf("rnd%0d_ovr", t), overrun, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
